// File: rtl/hamming74_secded_dec_if.sv
// Streaming bus for the Hamming(7,4) SECDED decoder: code word in, corrected nibble plus status out.
interface hamming74_secded_dec_if;
  logic       i_valid;
  logic       o_ready;
  logic [6:0] i_hamming_code;
  logic       i_parity;
  logic       o_valid;
  logic       i_ready;
  logic [3:0] o_data;
  logic       o_corrected;
  logic       o_uncorrectable;
  logic [2:0] o_syndrome;

  modport slave (
    input  i_valid, i_hamming_code, i_parity, i_ready,
    output o_ready, o_valid, o_data, o_corrected, o_uncorrectable, o_syndrome
  );

  modport master (
    output i_valid, i_hamming_code, i_parity, i_ready,
    input  o_ready, o_valid, o_data, o_corrected, o_uncorrectable, o_syndrome
  );
endinterface

// File: rtl/hamming74_secded_dec.sv
// Two-stage Hamming(7,4) SECDED decoder with valid/ready backpressure and saturating error counters.
// Stage 1 computes syndrome and overall check; stage 2 classifies, corrects and drives the outputs.
module hamming74_secded_dec #(
  parameter int CNT_W     = 16,
  parameter bit SECDED_EN = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  hamming74_secded_dec_if.slave bus,
  input  logic                  i_cnt_clr,
  output logic [CNT_W-1:0]      o_corr_cnt,
  output logic [CNT_W-1:0]      o_uncorr_cnt
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [6:0] code;
    logic [2:0] syn;
    logic       q;
  } s1_t;

  logic [STAGES:1] vld_pipe;
  s1_t             s1_d, s1_q;
  logic            s1_ready, s2_ready;

  // A stage can take a word when empty or when its content moves on this cycle.
  assign s2_ready    = !vld_pipe[2] | bus.i_ready;
  assign s1_ready    = !vld_pipe[1] | s2_ready;
  assign bus.o_ready = s1_ready;
  assign bus.o_valid = vld_pipe[2];

  always_comb begin
    s1_d      = '0;
    s1_d.code = bus.i_hamming_code;
    s1_d.syn  = {bus.i_hamming_code[3] ^ bus.i_hamming_code[4] ^ bus.i_hamming_code[5] ^ bus.i_hamming_code[6],
                 bus.i_hamming_code[1] ^ bus.i_hamming_code[2] ^ bus.i_hamming_code[5] ^ bus.i_hamming_code[6],
                 bus.i_hamming_code[0] ^ bus.i_hamming_code[2] ^ bus.i_hamming_code[4] ^ bus.i_hamming_code[6]};
    s1_d.q    = SECDED_EN ? ((^bus.i_hamming_code) ^ bus.i_parity) : 1'b0;
  end

  logic       syn_nz, corr, uncorr;
  logic [6:0] flip, fixed;

  // Nonzero syndrome with an even overall check means two bits flipped: leave the word raw.
  always_comb begin
    syn_nz = |s1_q.syn;
    uncorr = syn_nz & ~s1_q.q & SECDED_EN;
    corr   = syn_nz ? ~uncorr : s1_q.q;
    flip   = (syn_nz && !uncorr) ? (7'd1 << (s1_q.syn - 3'd1)) : 7'd0;
    fixed  = s1_q.code ^ flip;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_pipe            <= '0;
      s1_q                <= '0;
      bus.o_data          <= '0;
      bus.o_corrected     <= 1'b0;
      bus.o_uncorrectable <= 1'b0;
      bus.o_syndrome      <= '0;
    end else begin
      if (s1_ready) begin
        vld_pipe[1] <= bus.i_valid;
        if (bus.i_valid) s1_q <= s1_d;
      end
      if (s2_ready) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          bus.o_data          <= {fixed[6], fixed[5], fixed[4], fixed[2]};
          bus.o_corrected     <= corr;
          bus.o_uncorrectable <= uncorr;
          bus.o_syndrome      <= s1_q.syn;
        end
      end
    end
  end

  logic out_hs;
  assign out_hs = bus.o_valid & bus.i_ready;

  // Counted once per delivered word; clear wins over a coincident increment.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_cnt_clr) begin
      o_corr_cnt   <= '0;
      o_uncorr_cnt <= '0;
    end else begin
      if (out_hs && bus.o_corrected && (o_corr_cnt != '1))
        o_corr_cnt <= o_corr_cnt + CNT_W'(1);
      if (out_hs && bus.o_uncorrectable && (o_uncorr_cnt != '1))
        o_uncorr_cnt <= o_uncorr_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hamming74_secded_dec.sv
// Scoreboard bench: three decoder builds (SECDED/16-bit, SECDED/2-bit counters, plain SEC) fed identical streams.
module tb_hamming74_secded_dec;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, tb_valid, tb_parity, tb_ready, cnt_clr, rand_ready;
  logic [6:0] tb_code;

  hamming74_secded_dec_if bus();
  hamming74_secded_dec_if bus_sat();
  hamming74_secded_dec_if bus_sec();

  assign bus.i_valid = tb_valid;      assign bus.i_hamming_code = tb_code;
  assign bus.i_parity = tb_parity;    assign bus.i_ready = tb_ready;
  assign bus_sat.i_valid = tb_valid;  assign bus_sat.i_hamming_code = tb_code;
  assign bus_sat.i_parity = tb_parity; assign bus_sat.i_ready = tb_ready;
  assign bus_sec.i_valid = tb_valid;  assign bus_sec.i_hamming_code = tb_code;
  assign bus_sec.i_parity = tb_parity; assign bus_sec.i_ready = tb_ready;

  logic [15:0] corr_cnt, uncorr_cnt, sec_corr, sec_uncorr;
  logic [1:0]  sat_corr, sat_uncorr;

  hamming74_secded_dec #(.CNT_W(16), .SECDED_EN(1'b1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .i_cnt_clr(cnt_clr),
    .o_corr_cnt(corr_cnt), .o_uncorr_cnt(uncorr_cnt));
  hamming74_secded_dec #(.CNT_W(2), .SECDED_EN(1'b1)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_sat), .i_cnt_clr(cnt_clr),
    .o_corr_cnt(sat_corr), .o_uncorr_cnt(sat_uncorr));
  hamming74_secded_dec #(.CNT_W(16), .SECDED_EN(1'b0)) u_sec (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_sec), .i_cnt_clr(cnt_clr),
    .o_corr_cnt(sec_corr), .o_uncorr_cnt(sec_uncorr));

  typedef struct packed {
    logic [3:0] d;
    logic       c;
    logic       u;
    logic [2:0] s;
  } exp_t;

  exp_t q_main[$];
  exp_t q_sec[$];
  int   ncmp = 0;
  int   nfail = 0;
  int   exp_corr = 0;
  int   exp_uncorr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  // Monitors: pop on each output handshake, and verify held outputs do not move under stall.
  exp_t prev_m, prev_s;
  logic held_m = 1'b0, held_s = 1'b0;
  always @(negedge clk) begin
    exp_t act, e;
    if (!rst_n) held_m = 1'b0;
    else begin
      act = {bus.o_data, bus.o_corrected, bus.o_uncorrectable, bus.o_syndrome};
      if (held_m) begin
        chk("main_hold_valid", 32'(bus.o_valid), 32'd1);
        chk("main_hold_out", 32'(act), 32'(prev_m));
      end
      if (bus.o_valid && bus.i_ready) begin
        if (q_main.size() == 0) begin
          ncmp++; nfail++;
          $display("FAIL main_unexpected: got output %0h expected none", act);
        end else begin
          e = q_main.pop_front();
          chk("main_out", 32'(act), 32'(e));
        end
      end
      held_m = bus.o_valid && !bus.i_ready;
      prev_m = act;
    end
  end

  always @(negedge clk) begin
    exp_t act, e;
    if (!rst_n) held_s = 1'b0;
    else begin
      act = {bus_sec.o_data, bus_sec.o_corrected, bus_sec.o_uncorrectable, bus_sec.o_syndrome};
      if (held_s) chk("sec_hold_out", 32'(act), 32'(prev_s));
      if (bus_sec.o_valid && bus_sec.i_ready) begin
        if (q_sec.size() == 0) begin
          ncmp++; nfail++;
          $display("FAIL sec_unexpected: got output %0h expected none", act);
        end else begin
          e = q_sec.pop_front();
          chk("sec_out", 32'(act), 32'(e));
        end
      end
      held_s = bus_sec.o_valid && !bus_sec.i_ready;
      prev_s = act;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) tb_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [6:0] c, input logic p, input exp_t em, input exp_t es);
    int  n;
    logic acc;
    q_main.push_back(em);
    q_sec.push_back(es);
    if (em.c) exp_corr++;
    if (em.u) exp_uncorr++;
    tb_valid = 1'b1; tb_code = c; tb_parity = p;
    n = 0; acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk); acc = bus.o_ready;
      @(posedge clk); #1; n++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    tb_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_main.size() != 0 || q_sec.size() != 0) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_left", 32'(q_main.size() + q_sec.size()), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_corr"}, 32'(corr_cnt), 32'(exp_corr));
    chk({tag, "_uncorr"}, 32'(uncorr_cnt), 32'(exp_uncorr));
    chk({tag, "_sat_corr"}, 32'(sat_corr), 32'((exp_corr > 3) ? 3 : exp_corr));
    chk({tag, "_sat_uncorr"}, 32'(sat_uncorr), 32'((exp_uncorr > 3) ? 3 : exp_uncorr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] c;
    int n;
    rst_n = 1'b0; tb_valid = 1'b0; tb_code = '0; tb_parity = 1'b0;
    tb_ready = 1'b1; cnt_clr = 1'b0; rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_out", 32'({bus.o_data, bus.o_corrected, bus.o_uncorrectable, bus.o_syndrome}), 32'd0);
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk_cnts("rst");

    // Clean word with latency check: output appears on the second edge after acceptance.
    send(7'h55, 1'b0, {4'hB, 1'b0, 1'b0, 3'd0}, {4'hB, 1'b0, 1'b0, 3'd0});
    chk("lat_edge1", 32'(bus.o_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge2", 32'(bus.o_valid), 32'd1);
    drain();

    send(7'h45, 1'b0, {4'hB, 1'b1, 1'b0, 3'd5}, {4'hB, 1'b1, 1'b0, 3'd5});
    drain();
    chk_cnts("single");

    // Parity-bit error: corrected under SECDED, invisible under plain SEC.
    send(7'h55, 1'b1, {4'hB, 1'b1, 1'b0, 3'd0}, {4'hB, 1'b0, 1'b0, 3'd0});
    // Double error on p1/p2: data bits untouched so raw nibble is B; SEC miscorrects bit 2 giving A.
    send(7'h56, 1'b0, {4'hB, 1'b0, 1'b1, 3'd3}, {4'hA, 1'b1, 1'b0, 3'd3});
    drain();
    chk_cnts("double");

    // Back-to-back stream under random backpressure.
    rand_ready = 1'b1;
    for (int d = 0; d < 16; d++) begin
      c = enc(4'(d));
      send(c, ^c, {4'(d), 1'b0, 1'b0, 3'd0}, {4'(d), 1'b0, 1'b0, 3'd0});
    end
    rand_ready = 1'b0; tb_ready = 1'b1;
    drain();
    chk_cnts("stream");

    cnt_clr = 1'b1; @(posedge clk); #1; cnt_clr = 1'b0;
    exp_corr = 0; exp_uncorr = 0;
    chk_cnts("clr");

    // Five single errors at positions 1..5: 2-bit counter must saturate at 3.
    for (int k = 0; k < 5; k++) begin
      c = enc(4'(k + 1));
      send(c ^ (7'd1 << k), ^c, {4'(k + 1), 1'b1, 1'b0, 3'(k + 1)}, {4'(k + 1), 1'b1, 1'b0, 3'(k + 1)});
    end
    drain();
    chk_cnts("sat");

    // Sixth single error: clear coincides with its output handshake.
    tb_ready = 1'b0;
    c = enc(4'd7);
    send(c ^ 7'h20, ^c, {4'd7, 1'b1, 1'b0, 3'd6}, {4'd7, 1'b1, 1'b0, 3'd6});
    n = 0;
    while (!bus.o_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("clr_hs_valid", 32'(bus.o_valid), 32'd1);
    tb_ready = 1'b1; cnt_clr = 1'b1;
    @(posedge clk); #1; cnt_clr = 1'b0;
    exp_corr = 0; exp_uncorr = 0;
    drain();
    chk_cnts("clr_hs");

    // Reset with both stages full: in-flight words are dropped.
    tb_ready = 1'b0;
    c = enc(4'd3);
    send(c ^ 7'h01, ^c, {4'd3, 1'b1, 1'b0, 3'd1}, {4'd3, 1'b1, 1'b0, 3'd1});
    c = enc(4'd4);
    send(c ^ 7'h02, ^c, {4'd4, 1'b1, 1'b0, 3'd2}, {4'd4, 1'b1, 1'b0, 3'd2});
    chk("full_ready", 32'(bus.o_ready), 32'd0);
    rst_n = 1'b0;
    q_main.delete(); q_sec.delete();
    @(posedge clk); #1;
    chk("rst_flight_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_flight_sec_valid", 32'(bus_sec.o_valid), 32'd0);
    rst_n = 1'b1; tb_ready = 1'b1;
    exp_corr = 0; exp_uncorr = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_rst_valid", 32'(bus.o_valid), 32'd0);
    end
    chk_cnts("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
